// File: rtl/gmii_frame_gen.sv
// GMII traffic source: replays frames from a write-loadable memory, wrapping each one
// in preamble/SFD and an inter-frame gap, and fans the bytes out to NUM_CH enabled lanes.
module gmii_frame_gen #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 12,
  parameter int IFG_CYCLES = 12,
  parameter int PRE_LEN    = 7
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [8:0]            mem_wdata,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [15:0]           num_frames,
  input  logic [NUM_CH-1:0]     ch_enable,
  output logic [8*NUM_CH-1:0]   gmii_txd,
  output logic [NUM_CH-1:0]     gmii_tx_en,
  output logic                  busy,
  output logic [15:0]           frame_count
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IFG} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         frames_q, frames_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                stop_seen_q, stop_seen_d;
  logic                busy_q, busy_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   tx_en_q, tx_en_d;
  logic [8*NUM_CH-1:0] txd_q, txd_d;
  logic [7:0]          lane_byte;
  logic                lane_active;
  logic [8:0]          mem [0:(1<<ADDR_W)-1];
  logic [8:0]          rd_data_q;

  // Reading at the next-state address keeps rd_data_q equal to mem[addr_q],
  // so the first byte is ready on entry to DATA and bytes stream back to back.
  always_ff @(posedge sys_clk) begin
    if (mem_we && !busy_q) mem[mem_addr] <= mem_wdata;
    rd_data_q <= mem[addr_d];
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    frames_d      = frames_q;
    frame_count_d = frame_count_q;
    stop_seen_d   = stop_seen_q;
    mask_d        = mask_q;
    case (state_q)
      IDLE: begin
        if (start && num_frames != 16'd0) begin
          state_d       = PRE;
          addr_d        = '0;
          cnt_d         = '0;
          frames_d      = '0;
          frame_count_d = '0;
          mask_d        = ch_enable;
        end
      end
      PRE: begin
        if (cnt_q == 16'(PRE_LEN - 1)) begin
          state_d = SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SFD: state_d = DATA;
      DATA: begin
        addr_d = addr_q + ADDR_W'(1);
        if (rd_data_q[8]) begin
          state_d  = IFG;
          cnt_d    = '0;
          frames_d = frames_q + 16'd1;
          if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
        end
      end
      IFG: begin
        if (cnt_q == 16'(IFG_CYCLES - 1)) begin
          cnt_d = '0;
          if (stop_seen_q || stop) begin
            state_d = IDLE;
          end else if (frames_q < num_frames) begin
            state_d = PRE;
            mask_d  = ch_enable;
          end else if (loop) begin
            state_d  = PRE;
            mask_d   = ch_enable;
            addr_d   = '0;
            frames_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A stop pulse that coincides with an accepted start still counts for that run.
    if (stop) stop_seen_d = 1'b1;
    if (state_d == IDLE) stop_seen_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    lane_active = 1'b1;
    lane_byte   = 8'h00;
    tx_en_d     = '0;
    txd_d       = '0;
    case (state_q)
      PRE:     lane_byte = 8'h55;
      SFD:     lane_byte = 8'hD5;
      DATA:    lane_byte = rd_data_q[7:0];
      default: lane_active = 1'b0;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      tx_en_d[n]      = lane_active & mask_q[n];
      txd_d[8*n +: 8] = (lane_active && mask_q[n]) ? lane_byte : 8'h00;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      frames_q      <= '0;
      frame_count_q <= '0;
      stop_seen_q   <= 1'b0;
      busy_q        <= 1'b0;
      mask_q        <= '0;
      tx_en_q       <= '0;
      txd_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      frames_q      <= frames_d;
      frame_count_q <= frame_count_d;
      stop_seen_q   <= stop_seen_d;
      busy_q        <= busy_d;
      mask_q        <= mask_d;
      tx_en_q       <= tx_en_d;
      txd_q         <= txd_d;
    end
  end

  assign gmii_txd    = txd_q;
  assign gmii_tx_en  = tx_en_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_gmii_frame_gen.sv
// Bench for gmii_frame_gen: a frame-level model expands the memory image into the
// expected per-cycle lane stream, which is compared against the DUT every cycle.
module tb_gmii_frame_gen;
  localparam int NUM_CH     = 4;
  localparam int ADDR_W     = 12;
  localparam int IFG_CYCLES = 12;
  localparam int PRE_LEN    = 7;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int W          = 9 * NUM_CH;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [8:0]          mem_wdata;
  logic                start;
  logic                stop;
  logic                loop;
  logic [15:0]         num_frames;
  logic [NUM_CH-1:0]   ch_enable;
  logic [8*NUM_CH-1:0] gmii_txd;
  logic [NUM_CH-1:0]   gmii_tx_en;
  logic                busy;
  logic [15:0]         frame_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_frames;
  logic [8:0] ref_mem [0:DEPTH-1];
  logic [W-1:0] exp_q[$];

  gmii_frame_gen #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .IFG_CYCLES(IFG_CYCLES), .PRE_LEN(PRE_LEN)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .start(start), .stop(stop), .loop(loop),
    .num_frames(num_frames), .ch_enable(ch_enable), .gmii_txd(gmii_txd),
    .gmii_tx_en(gmii_tx_en), .busy(busy), .frame_count(frame_count)
  );

  always #4 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input int a, input logic [8:0] d);
    mem_we    = 1'b1;
    mem_addr  = ADDR_W'(a);
    mem_wdata = d;
    @(posedge sys_clk); #1;
    mem_we    = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic load_frame(input int base, input int len, input bit seq);
    for (int k = 0; k < len; k++)
      mem_write(base + k, {(k == len - 1), seq ? 8'(base + k) : 8'($urandom)});
  endtask

  function automatic void push(input logic [NUM_CH-1:0] m, input logic [7:0] b, input bit act);
    logic [8*NUM_CH-1:0] d = '0;
    logic [NUM_CH-1:0]   e = '0;
    for (int l = 0; l < NUM_CH; l++)
      if (act && m[l]) begin
        e[l]         = 1'b1;
        d[8*l +: 8]  = b;
      end
    exp_q.push_back({e, d});
  endfunction

  // Frame-level view: walk memory from address 0, one frame per last bit, restarting
  // at 0 when a looped pass is done; 'total' caps the frames a stop allows.
  function automatic void build(input int nf, input bit lp, input int total,
                                input logic [NUM_CH-1:0] m0, input logic [NUM_CH-1:0] m1);
    int a;
    int in_pass;
    int n;
    bit last;
    logic [NUM_CH-1:0] m;
    a       = 0;
    in_pass = 0;
    n       = lp ? total : ((total < nf) ? total : nf);
    exp_q.delete();
    for (int f = 0; f < n; f++) begin
      m = (f == 0) ? m0 : m1;
      if (in_pass == nf) begin
        a       = 0;
        in_pass = 0;
      end
      for (int k = 0; k < PRE_LEN; k++) push(m, 8'h55, 1'b1);
      push(m, 8'hD5, 1'b1);
      do begin
        push(m, ref_mem[a][7:0], 1'b1);
        last = ref_mem[a][8];
        a    = (a + 1) % DEPTH;
      end while (!last);
      in_pass++;
      for (int k = 0; k < IFG_CYCLES; k++) push(m, 8'h00, 1'b0);
    end
    for (int k = 0; k < 8; k++) push(m0, 8'h00, 1'b0);
    exp_frames = n;
  endfunction

  // stop_at = -2 raises stop together with start; -1 disables an option.
  task automatic run(input string tag, input int nf, input bit lp,
                     input logic [NUM_CH-1:0] m0, input logic [NUM_CH-1:0] m1,
                     input int chg_at, input int stop_at, input int we_at, input int rst_at);
    num_frames = 16'(nf);
    loop       = lp;
    ch_enable  = m0;
    mem_addr   = ADDR_W'(5);
    mem_wdata  = 9'h0FF;
    @(posedge sys_clk); #1;
    start = 1'b1;
    stop  = (stop_at == -2);
    @(posedge sys_clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge sys_clk);
    check({tag, " lanes_before_preamble"}, {gmii_tx_en, gmii_txd}, '0);
    check({tag, " busy_after_start"}, busy, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge sys_clk);
      if (i == rst_at) begin
        #1 sys_rst = 1'b1;
        #1;
        check({tag, " rst_tx_en"}, gmii_tx_en, 0);
        check({tag, " rst_txd"}, gmii_txd, 0);
        check({tag, " rst_busy"}, busy, 0);
        check({tag, " rst_frame_count"}, frame_count, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        return;
      end
      check($sformatf("%s cycle%0d", tag, i), {gmii_tx_en, gmii_txd}, exp_q[i]);
      stop   = (i == stop_at);
      mem_we = (i == we_at);
      if (i == chg_at) ch_enable = m1;
    end
    stop   = 1'b0;
    mem_we = 1'b0;
    check({tag, " busy_at_end"}, busy, 0);
    check({tag, " frame_count"}, frame_count, 64'(exp_frames));
  endtask

  initial begin
    int l0, l1, l2;
    logic [NUM_CH-1:0] rm;
    sys_rst    = 1'b1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    start      = 1'b0;
    stop       = 1'b0;
    loop       = 1'b0;
    num_frames = '0;
    ch_enable  = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset txd", gmii_txd, 0);
    check("reset tx_en", gmii_tx_en, 0);
    check("reset busy", busy, 0);
    check("reset frame_count", frame_count, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    mem_we = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      mem_addr   = ADDR_W'(a);
      mem_wdata  = '0;
      ref_mem[a] = '0;
      @(posedge sys_clk); #1;
    end
    mem_we = 1'b0;

    load_frame(0, 60, 1'b1);
    build(1, 1'b0, 1000, 4'b1111, 4'b1111);
    run("seq60", 1, 1'b0, 4'b1111, 4'b1111, -1, -1, -1, -1);

    load_frame(0, 10, 1'b0);
    load_frame(10, 20, 1'b0);
    @(posedge sys_clk); #1 stop = 1'b1;
    @(posedge sys_clk); #1 stop = 1'b0;
    check("idle_stop busy", busy, 0);
    build(2, 1'b0, 1000, 4'b1111, 4'b1111);
    run("two_frames", 2, 1'b0, 4'b1111, 4'b1111, -1, -1, -1, -1);

    build(2, 1'b1, 4, 4'b1111, 4'b1111);
    run("loop_stop", 2, 1'b1, 4'b1111, 4'b1111, -1, 110, -1, -1);

    build(2, 1'b1, 1, 4'b1111, 4'b1111);
    run("start_with_stop", 2, 1'b1, 4'b1111, 4'b1111, -1, -2, -1, -1);

    build(2, 1'b0, 1000, 4'b0101, 4'b0010);
    run("mask", 2, 1'b0, 4'b0101, 4'b0010, 5, -1, -1, -1);

    build(2, 1'b0, 1000, 4'b1111, 4'b1111);
    run("busy_write", 2, 1'b0, 4'b1111, 4'b1111, -1, -1, 20, -1);
    build(1, 1'b0, 1000, 4'b1111, 4'b1111);
    run("replay_after_write", 1, 1'b0, 4'b1111, 4'b1111, -1, -1, -1, -1);

    num_frames = 16'd0;
    @(posedge sys_clk); #1 start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      check($sformatf("zero_frames busy%0d", k), busy, 0);
      check($sformatf("zero_frames tx_en%0d", k), gmii_tx_en, 0);
    end

    build(2, 1'b0, 1000, 4'b1111, 4'b1111);
    run("mid_reset", 2, 1'b0, 4'b1111, 4'b1111, -1, -1, -1, 12);
    build(2, 1'b0, 1000, 4'b1111, 4'b1111);
    run("after_reset", 2, 1'b0, 4'b1111, 4'b1111, -1, -1, -1, -1);

    for (int t = 0; t < 3; t++) begin
      l0 = 1;
      l1 = $urandom_range(1, 40);
      l2 = $urandom_range(1, 40);
      rm = NUM_CH'($urandom_range(1, 15));
      load_frame(0, l0, 1'b0);
      load_frame(l0, l1, 1'b0);
      load_frame(l0 + l1, l2, 1'b0);
      build(3, 1'b0, 1000, rm, rm);
      run($sformatf("random%0d", t), 3, 1'b0, rm, rm, -1, -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
